multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle ARM datapath. It is a Moore-style main FSM, plus an ALU decoder, a registered NZCV flag store and condition-check logic. It sequences each instruction through fetch, decode, execute, memory and writeback by driving the datapath's write enables and mux selects, and it drives the memory write enable. Supported instructions:
- Data-processing: AND, SUB, ADD, ORR, CMP (register or imm8).
- LDR/STR with U=1 imm12 offset.
- B.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Instr_fields`  in  20  Instr[31:12]: cond[31:28], op[27:26], funct[25:20] (I=25, cmd=24:21, S=20), Rd[15:12].
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU, valid in the current cycle.
- `PCWrite`  out  1  PC <= Result.
- `RegWrite`  out  1  register file write of Result to Rd.
- `MemWrite`  out  1  data memory write of WriteData at Adr.
- `IRWrite`  out  1  Instr <= ReadData.
- `AdrSrc`  out  1  0 = PC, 1 = Result.
- `ALUSrcA`  out  1  0 = A, 1 = PC.
- `ALUSrcB`  out  2  00 = B, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `RegSrc`  out  2  [0] = 1 selects RA1 = R15; [1] = 1 selects RA2 = Rd.
- `ImmSrc`  out  2  00 = imm8, 01 = imm12, 10 = imm24 branch.
- `ALUCtrl`  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.

## Operation
- States, 4-bit encoding: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Instruction-field decode is combinational:
  - RegSrc[0] = (op == 10).
  - RegSrc[1] = (op == 01).
  - ImmSrc = op.
- Transitions:
  - FETCH → DECODE.
  - From DECODE, by op:
    - op 00 with I = 0 → EXECR.
    - op 00 with I = 1 → EXECI.
    - op 01 → MEMADR.
    - op 10 → BRANCH.
    - op 11 → FETCH (unsupported, no side effects).
  - From MEMADR, by funct[0]: 1 (L) → MEMREAD, 0 → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR and EXECI → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH → FETCH.
- Outputs per state (signals not listed are 0, or 00 for vectors):
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 1, ALUSrcB 10, ALUCtrl 00, ResultSrc 10, PCWrite 1.
  - DECODE: ALUSrcA 1, ALUSrcB 10, ALUCtrl 00, ResultSrc 10. This makes R15 read as PC+8.
  - MEMADR: ALUSrcA 0, ALUSrcB 01, ALUCtrl 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite = CondEx.
  - MEMWB: ResultSrc 01, then one of:
    - Rd = 15: PCWrite = CondEx, RegWrite 0.
    - Rd ≠ 15: RegWrite = CondEx.
  - EXECR: ALUSrcA 0, ALUSrcB 00, ALUCtrl from the ALU decoder.
  - EXECI: ALUSrcA 0, ALUSrcB 01, ALUCtrl from the ALU decoder.
  - ALUWB: ResultSrc 00, then one of:
    - CMP: no write.
    - Rd = 15: PCWrite = CondEx.
    - Otherwise: RegWrite = CondEx.
  - BRANCH: ALUSrcA 0, ALUSrcB 01, ALUCtrl 00, ResultSrc 10, PCWrite = CondEx.
- ALU decoder, by cmd:
  - 0100 → ADD.
  - 0010 → SUB.
  - 0000 → AND.
  - 1100 → ORR.
  - 1010 → CMP: SUB, S forced to 1, no register write.
  - Any other cmd → ALUCtrl 00 and no register, flag or PC write; the instruction still takes 4 cycles.
- Flag store: a 4-bit NZCV register, updated on the clk edge at the end of EXECR or EXECI when S = 1 and CondEx = 1.
  - ADD, SUB and CMP update all four flags.
  - AND and ORR update N and Z only; C and V hold.
- CondEx is combinational from cond and the stored flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; cond 1111 → 0.
- A failed condition suppresses every architectural write except the FETCH PC+4 update. The state sequence is unchanged.

## Timing
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, unsupported op 2.
- All outputs are combinational from state, Instr_fields and stored flags. There are no output registers.
- Reset asserted (low):
  - State goes to FETCH and flags go to 0000 immediately (asynchronous).
  - PCWrite, RegWrite, MemWrite and IRWrite are forced to 0 for as long as Reset is low.
  - Mux selects show their FETCH values.
- Reset mid-instruction: the instruction is abandoned with no partial writes. The first edge after release executes FETCH.
- Flags written in EXECR/EXECI are visible to CondEx from the next cycle. A flag-setting instruction followed by a conditional one therefore sees the new flags.

## Test plan
- Reset low for 2 cycles, then high: IRWrite = 1 and PCWrite = 1 in cycle 0. All enables are 0 while Reset is low.
- ADD R1, R2, R3 (cond E, funct 001000): state sequence FETCH, DECODE, EXECR, ALUWB.
  - EXECR: ALUSrcB 00, ALUCtrl 00.
  - ALUWB: RegWrite 1.
  - Flags unchanged.
- CMP (funct 010101), ALUFlags 0100 in EXECR, followed by BEQ (cond 0000): flags become 0100. BRANCH state asserts PCWrite = 1. The same sequence with ALUFlags 0000 gives PCWrite = 0.
- LDR (op 01, L = 1): 5-cycle sequence ending in MEMWB.
  - MEMREAD: AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - Repeat with Rd = 15: PCWrite 1, RegWrite 0.
- STR with cond NE while Z = 1: 4-cycle sequence, MemWrite stays 0. With Z = 0: MemWrite 1 in MEMWRITE.
- Reset pulsed low during MEMREAD: the next state is FETCH and no RegWrite occurs. The op 11 instruction that follows returns DECODE → FETCH with no writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM datapath: main FSM, ALU decoder,
// NZCV flag store and condition check, with Moore outputs decoded from state.
module multicycle_controller (
  input  logic        clk,
  input  logic        Reset,
  input  logic [19:0] Instr_fields,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUCtrl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state;
  logic [3:0] flags;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       i_bit;
  logic       s_bit;
  logic       unused_rn;

  assign cond      = Instr_fields[19:16];
  assign op        = Instr_fields[15:14];
  assign funct     = Instr_fields[13:8];
  assign rd        = Instr_fields[3:0];
  assign i_bit     = funct[5];
  assign cmd       = funct[4:1];
  assign s_bit     = funct[0];
  assign unused_rn = ^Instr_fields[7:4];

  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign ImmSrc = op;

  logic [1:0] dec_ctrl;
  logic       cmd_ok;
  logic       is_cmp;
  logic       nz_only;
  logic       flag_set;
  logic       write_rd;

  // Unsupported commands fall through as a harmless ADD with every write suppressed.
  always_comb begin
    dec_ctrl = 2'b00;
    cmd_ok   = 1'b1;
    is_cmp   = 1'b0;
    nz_only  = 1'b0;
    case (cmd)
      4'b0100: dec_ctrl = 2'b00;
      4'b0010: dec_ctrl = 2'b01;
      4'b0000: begin dec_ctrl = 2'b10; nz_only = 1'b1; end
      4'b1100: begin dec_ctrl = 2'b11; nz_only = 1'b1; end
      4'b1010: begin dec_ctrl = 2'b01; is_cmp  = 1'b1; end
      default: cmd_ok = 1'b0;
    endcase
  end

  assign flag_set = cmd_ok & (s_bit | is_cmp);
  assign write_rd = cmd_ok & ~is_cmp;

  logic n_f, z_f, c_f, v_f;
  logic cond_ex;

  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = z_f;
      4'h1: cond_ex = ~z_f;
      4'h2: cond_ex = c_f;
      4'h3: cond_ex = ~c_f;
      4'h4: cond_ex = n_f;
      4'h5: cond_ex = ~n_f;
      4'h6: cond_ex = v_f;
      4'h7: cond_ex = ~v_f;
      4'h8: cond_ex = c_f & ~z_f;
      4'h9: cond_ex = ~c_f | z_f;
      4'hA: cond_ex = (n_f == v_f);
      4'hB: cond_ex = (n_f != v_f);
      4'hC: cond_ex = ~z_f & (n_f == v_f);
      4'hD: cond_ex = z_f | (n_f != v_f);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= FETCH;
      flags <= 4'b0000;
    end else begin
      case (state)
        FETCH:   state <= DECODE;
        DECODE: begin
          case (op)
            2'b00:   state <= i_bit ? EXECI : EXECR;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:  state <= funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD: state <= MEMWB;
        EXECR:   state <= ALUWB;
        EXECI:   state <= ALUWB;
        default: state <= FETCH;
      endcase
      // Logical ops leave C and V untouched.
      if ((state == EXECR || state == EXECI) && flag_set && cond_ex) begin
        if (nz_only) flags[3:2] <= ALUFlags[3:2];
        else         flags      <= ALUFlags;
      end
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUCtrl   = 2'b00;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        if (rd == 4'd15) PCWrite  = cond_ex;
        else             RegWrite = cond_ex;
      end
      EXECR:    ALUCtrl = dec_ctrl;
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUCtrl = dec_ctrl;
      end
      ALUWB: begin
        if (write_rd && rd == 4'd15) PCWrite  = cond_ex;
        else if (write_rd)           RegWrite = cond_ex;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    if (!Reset) begin
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: stimulus pushes one
// expected output word per cycle, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic        clk;
  logic        Reset;
  logic [19:0] Instr_fields;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUCtrl;

  multicycle_controller dut (
    .clk          (clk),
    .Reset        (Reset),
    .Instr_fields (Instr_fields),
    .ALUFlags     (ALUFlags),
    .PCWrite      (PCWrite),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .AdrSrc       (AdrSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ResultSrc    (ResultSrc),
    .RegSrc       (RegSrc),
    .ImmSrc       (ImmSrc),
    .ALUCtrl      (ALUCtrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction fields: {cond, op, funct, Rn, Rd}
  localparam logic [19:0] F_ADD   = {4'hE, 2'b00, 6'b001000, 4'd2, 4'd1};
  localparam logic [19:0] F_CMP   = {4'hE, 2'b00, 6'b010101, 4'd1, 4'd0};
  localparam logic [19:0] F_BEQ   = {4'h0, 2'b10, 6'b000000, 4'd0, 4'd0};
  localparam logic [19:0] F_BCS   = {4'h2, 2'b10, 6'b000000, 4'd0, 4'd0};
  localparam logic [19:0] F_BMI   = {4'h4, 2'b10, 6'b000000, 4'd0, 4'd0};
  localparam logic [19:0] F_LDR   = {4'hE, 2'b01, 6'b011001, 4'd2, 4'd1};
  localparam logic [19:0] F_LDRPC = {4'hE, 2'b01, 6'b011001, 4'd2, 4'd15};
  localparam logic [19:0] F_STRNE = {4'h1, 2'b01, 6'b011000, 4'd2, 4'd3};
  localparam logic [19:0] F_ORRS  = {4'hE, 2'b00, 6'b111001, 4'd1, 4'd4};
  localparam logic [19:0] F_OP11  = {4'hE, 2'b11, 6'b000000, 4'd0, 4'd0};

  typedef struct {
    string       tag;
    logic [15:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  // Word layout: {PCWrite,RegWrite,MemWrite,IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUCtrl}
  function automatic logic [15:0] ev(input logic [3:0] en, input logic adr, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] res,
                                     input logic [1:0] regsrc, input logic [1:0] imm,
                                     input logic [1:0] ctrl);
    return {en, adr, srca, srcb, res, regsrc, imm, ctrl};
  endfunction

  logic [15:0] got;
  assign got = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUCtrl};

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  // One cycle of stimulus; outputs are sampled on the following negedge.
  task automatic applyStimulus(input string tag, input logic rst, input logic [19:0] f,
                               input logic [3:0] fl, input logic [15:0] e);
    exp_t item;
    @(posedge clk);
    #1;
    Reset        = rst;
    Instr_fields = f;
    ALUFlags     = fl;
    item.tag = tag;
    item.vec = e;
    sb.push_back(item);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checkOutput(cur.tag, got, cur.vec);
    end
  end

  task automatic fetch_decode(input string tag, input logic [19:0] f,
                              input logic [1:0] regsrc, input logic [1:0] imm);
    applyStimulus({tag, "_fetch"},  1'b1, f, 4'b0000, ev(4'b1001, 1'b0, 1'b1, 2'b10, 2'b10, regsrc, imm, 2'b00));
    applyStimulus({tag, "_decode"}, 1'b1, f, 4'b0000, ev(4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, regsrc, imm, 2'b00));
  endtask

  task automatic cmp_seq(input string tag, input logic [3:0] fl);
    fetch_decode(tag, F_CMP, 2'b00, 2'b00);
    applyStimulus({tag, "_execr"}, 1'b1, F_CMP, fl,      ev(4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    applyStimulus({tag, "_aluwb"}, 1'b1, F_CMP, 4'b0000, ev(4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
  endtask

  task automatic branch_seq(input string tag, input logic [19:0] f, input logic taken);
    fetch_decode(tag, f, 2'b01, 2'b10);
    applyStimulus({tag, "_branch"}, 1'b1, f, 4'b0000,
                  ev({taken, 3'b000}, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00));
  endtask

  task automatic ldr_seq(input string tag, input logic [19:0] f, input logic [3:0] wb_en);
    fetch_decode(tag, f, 2'b10, 2'b01);
    applyStimulus({tag, "_memadr"},  1'b1, f, 4'b0000, ev(4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00));
    applyStimulus({tag, "_memread"}, 1'b1, f, 4'b0000, ev(4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00));
    applyStimulus({tag, "_memwb"},   1'b1, f, 4'b0000, ev(wb_en,   1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00));
  endtask

  task automatic str_seq(input string tag, input logic mw);
    fetch_decode(tag, F_STRNE, 2'b10, 2'b01);
    applyStimulus({tag, "_memadr"},   1'b1, F_STRNE, 4'b0000, ev(4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00));
    applyStimulus({tag, "_memwrite"}, 1'b1, F_STRNE, 4'b0000,
                  ev({2'b00, mw, 1'b0}, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00));
  endtask

  initial begin
    Reset        = 1'b1;
    Instr_fields = F_ADD;
    ALUFlags     = 4'b0000;
    #2 Reset = 1'b0;

    // Reset held: FETCH mux values, every enable low
    applyStimulus("reset_c0", 1'b0, F_ADD, 4'b0000, ev(4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    applyStimulus("reset_c1", 1'b0, F_ADD, 4'b0000, ev(4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));

    // ADD R1,R2,R3 with S=0: ALUFlags in EXECR must not reach the flag store
    fetch_decode("add", F_ADD, 2'b00, 2'b00);
    applyStimulus("add_execr", 1'b1, F_ADD, 4'b0100, ev(4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus("add_aluwb", 1'b1, F_ADD, 4'b0000, ev(4'b0100, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    branch_seq("beq_after_add", F_BEQ, 1'b0);

    // CMP sets Z, BEQ taken; CMP clears Z, BEQ not taken
    cmp_seq("cmp_z1", 4'b0100);
    branch_seq("beq_z1", F_BEQ, 1'b1);
    cmp_seq("cmp_z0", 4'b0000);
    branch_seq("beq_z0", F_BEQ, 1'b0);

    // LDR to R1, then LDR to PC
    ldr_seq("ldr_r1", F_LDR,   4'b0100);
    ldr_seq("ldr_pc", F_LDRPC, 4'b1000);

    // STRNE with Z=1 suppressed, with Z=0 performed
    cmp_seq("cmp_z1b", 4'b0100);
    str_seq("strne_z1", 1'b0);
    cmp_seq("cmp_z0b", 4'b0000);
    str_seq("strne_z0", 1'b1);

    // ORRS imm: only N and Z update, C stays 0 although ALUFlags C=1
    fetch_decode("orrs", F_ORRS, 2'b00, 2'b00);
    applyStimulus("orrs_execi", 1'b1, F_ORRS, 4'b1011, ev(4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11));
    applyStimulus("orrs_aluwb", 1'b1, F_ORRS, 4'b0000, ev(4'b0100, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    branch_seq("bcs_c_held", F_BCS, 1'b0);
    branch_seq("bmi_n_set",  F_BMI, 1'b1);

    // Reset pulsed during MEMREAD abandons the LDR
    fetch_decode("ldr_rst", F_LDR, 2'b10, 2'b01);
    applyStimulus("ldr_rst_memadr", 1'b1, F_LDR, 4'b0000, ev(4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00));
    applyStimulus("ldr_rst_pulse",  1'b0, F_LDR, 4'b0000, ev(4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00));

    // Unsupported op 11: DECODE straight back to FETCH
    fetch_decode("op11", F_OP11, 2'b00, 2'b11);
    applyStimulus("op11_refetch", 1'b1, F_OP11, 4'b0000, ev(4'b1001, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00));

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
